ps2_kbd_controller: RTL

PS2_KBD_CONTROLLER -- requirements
Module: ps2_kbd_controller

---
 rtl/ps2_kbd_pkg.sv | 41 ++++
 rtl/ps2_rx.sv | 179 +++++++++++++++++
 rtl/ps2_kbd_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_pkg.sv
// -----------------------------------------------------------------------------
// ps2_kbd_pkg
// Shared definitions for the PS/2 keyboard controller:
//   - receiver FSM state encoding
//   - status register bit positions
//   - host register-select values (A0)
//   - odd-parity helper used by the receiver
// -----------------------------------------------------------------------------
package ps2_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Status register layout: {3'b000, IE, PERR, OVF, FULL, NE}
    localparam int STAT_NE   = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;
    localparam int STAT_PERR = 3;
    localparam int STAT_IE   = 4;

    // Write-data bit positions
    localparam int WR_FLUSH     = 0;
    localparam int WR_CLR_OVF   = 2;
    localparam int WR_CLR_PERR  = 3;
    localparam int WR_IE        = 4;

    // Register select on A0
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host frame receiver.
//   - 2-flop synchronizers on kb_clk / kb_data, fall detect on synchronized clock
//   - one data sample SAMPLE_DELAY cycles after every fall
//   - FSM IDLE -> START -> DATA(x8, LSB first) -> PARITY -> STOP
//   - partial frame abandoned after TIMEOUT cycles without a fall
// Optional feature macro: PS2_PARITY_CHECK_EN (odd-parity check; a bad frame
// raises parity_err and is not delivered). Without it the parity bit is ignored.
//
// Ports:
//   CLK        in   system clock
//   RST        in   asynchronous reset, active-low
//   kb_clk     in   PS/2 clock (asynchronous)
//   kb_data    in   PS/2 data  (asynchronous)
//   byte_valid out  one-cycle pulse, byte_data holds a received byte
//   byte_data  out  last received byte
//   parity_err out  one-cycle pulse on a parity failure
//   busy       out  receiver is inside a frame (state != IDLE)
// -----------------------------------------------------------------------------
module ps2_rx
    import ps2_kbd_pkg::*;
#(
    parameter int SAMPLE_DELAY = 8,
    parameter int TIMEOUT      = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       kb_clk,
    input  logic       kb_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       parity_err,
    output logic       busy
);

    localparam int DLY_W = $clog2(SAMPLE_DELAY + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [1:0]       kb_clk_sync;
    logic [1:0]       kb_data_sync;
    logic             kb_clk_last;
    logic             fall;
    logic [DLY_W-1:0] dly_cnt;
    logic             sample_stb;
    logic             sample_bit;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_cnt;
    logic             shift_en;
    logic             frame_done;
    logic             parity_bad;

    // Synchronizers reset to 1 (PS/2 idle level) so reset release never
    // looks like a clock fall.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, whatever order the blocks run in.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            kb_clk_sync  <= 2'b11;
            kb_data_sync <= 2'b11;
            kb_clk_last  <= 1'b1;
        end else begin
            kb_clk_sync  <= {kb_clk_sync[0], kb_clk};
            kb_data_sync <= {kb_data_sync[0], kb_data};
            kb_clk_last  <= kb_clk_sync[1];
        end
    end

    assign fall       = kb_clk_last & ~kb_clk_sync[1];
    assign sample_bit = kb_data_sync[1];

    // Sample delay: loaded on a fall, the sample fires when it reaches 1,
    // i.e. SAMPLE_DELAY cycles after the fall. Zero means nothing pending.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dly_cnt <= '0;
        end else if (fall) begin
            dly_cnt <= DLY_W'(SAMPLE_DELAY);
        end else if (dly_cnt != '0) begin
            dly_cnt <= dly_cnt - 1'b1;
        end
    end

    assign sample_stb = (dly_cnt == DLY_W'(1));

    // Inactivity timer, restarted by every fall, only runs inside a frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            to_cnt <= '0;
        end else if (state == ST_IDLE || fall) begin
            to_cnt <= '0;
        end else if (!timeout) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT - 1));

    // FSM: state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state. The fall that leaves IDLE schedules the start-bit
    // sample, which is then judged in START.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (fall)       state_nxt = ST_START;
                ST_START:  if (sample_stb) state_nxt = sample_bit ? ST_IDLE : ST_DATA;
                ST_DATA:   if (sample_stb && bit_cnt == 3'd7) state_nxt = ST_PARITY;
                ST_PARITY: if (sample_stb) state_nxt = ST_STOP;
                ST_STOP:   if (sample_stb) state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy       = (state != ST_IDLE);
        shift_en   = (state == ST_DATA) && sample_stb;
        frame_done = (state == ST_STOP) && sample_stb && sample_bit && !parity_bad;
    end

    // Data path: bits arrive LSB first, so shift right inserting at the MSB.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= frame_done;
            if (state == ST_START) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shift_reg <= {sample_bit, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end
        end
    end

    assign byte_data = shift_reg;

`ifdef PS2_PARITY_CHECK_EN
    // parity_bad holds through STOP to suppress delivery of the byte.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (state == ST_START) begin
                parity_bad <= 1'b0;
            end else if (state == ST_PARITY && sample_stb) begin
                parity_bad <= !odd_parity_ok(shift_reg, sample_bit);
                parity_err <= !odd_parity_ok(shift_reg, sample_bit);
            end
        end
    end
`else
    assign parity_bad = 1'b0;
    assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/ps2_kbd_controller.sv
// -----------------------------------------------------------------------------
// ps2_kbd_controller
// PS/2 keyboard controller for an 8-bit I/O bus: receiver, scan-code FIFO and
// a two-register host interface (A0=0 data/flush, A0=1 status/control).
// Optional feature macro: PS2_PARITY_CHECK_EN (enables PERR via ps2_rx).
//
// Ports:
//   CLK     in   system clock
//   RST     in   asynchronous reset, active-low
//   CS_N    in   I/O select, active-low (decoded externally)
//   A0      in   register select
//   R       in   read strobe, active-low
//   W       in   write strobe, active-low (acts on its 0->1 edge)
//   D_IN    in   write data
//   D_OUT   out  read data, 0x00 when not driven
//   D_OE    out  drive enable for D_OUT (~CS_N & ~R)
//   KB_CLK  in   PS/2 clock
//   KB_DATA in   PS/2 data
//   INT_N   out  interrupt, active-low, registered ~(IE & NE)
//   BUSY    out  frame in progress
// -----------------------------------------------------------------------------
module ps2_kbd_controller
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,     // power of two, 2..16
    parameter int SAMPLE_DELAY = 8,
    parameter int TIMEOUT      = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CS_N,
    input  logic       A0,
    input  logic       R,
    input  logic       W,
    input  logic [7:0] D_IN,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    input  logic       KB_CLK,
    input  logic       KB_DATA,
    output logic       INT_N,
    output logic       BUSY
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             parity_err;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ne;
    logic             full;
    logic             push;
    logic             pop;
    logic             flush;

    logic             ie;
    logic             ovf;
    logic             perr;
    logic [7:0]       status;

    logic             data_rd_active;
    logic             rd_pending;
    logic             w_q;
    logic             w_rise;
    logic             wr_data;
    logic             wr_stat;
    logic             unused_ok;

    ps2_rx #(
        .SAMPLE_DELAY (SAMPLE_DELAY),
        .TIMEOUT      (TIMEOUT)
    ) u_rx (
        .CLK        (CLK),
        .RST        (RST),
        .kb_clk     (KB_CLK),
        .kb_data    (KB_DATA),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .parity_err (parity_err),
        .busy       (BUSY)
    );

    // ---------------- host strobes ----------------
    // A data read arms rd_pending; the pop happens on the first cycle R is
    // seen high again, so a long-held R pops once.
    assign data_rd_active = ~CS_N & ~R & (A0 == REG_DATA);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_pending <= 1'b0;
            w_q        <= 1'b1;
        end else begin
            w_q <= W;
            if (data_rd_active) begin
                rd_pending <= 1'b1;
            end else if (R) begin
                rd_pending <= 1'b0;
            end
        end
    end

    assign w_rise  = W & ~w_q & ~CS_N;
    assign wr_data = w_rise & (A0 == REG_DATA);
    assign wr_stat = w_rise & (A0 == REG_STATUS);
    assign flush   = wr_data & D_IN[WR_FLUSH];

    // ---------------- FIFO ----------------
    assign ne   = (count != '0);
    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign pop  = rd_pending & R & ne;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = byte_valid & (~full | pop);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage array has no reset; count/pointers define validity, and
    // leaving it out keeps it mappable to plain RAM.
    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            mem[wr_ptr] <= byte_data;
        end
    end

    // ---------------- control / status ----------------
    // Set beats clear when both land in the same cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ie    <= 1'b0;
            ovf   <= 1'b0;
            perr  <= 1'b0;
            INT_N <= 1'b1;
        end else begin
            if (wr_stat) begin
                ie <= D_IN[WR_IE];
                if (D_IN[WR_CLR_OVF])  ovf  <= 1'b0;
                if (D_IN[WR_CLR_PERR]) perr <= 1'b0;
            end
            if (byte_valid && full && !pop && !flush) ovf <= 1'b1;
            if (parity_err) perr <= 1'b1;
            INT_N <= ~(ie & ne);
        end
    end

    always_comb begin
        status            = 8'h00;
        status[STAT_NE]   = ne;
        status[STAT_FULL] = full;
        status[STAT_OVF]  = ovf;
        status[STAT_PERR] = perr;
        status[STAT_IE]   = ie;
    end

    // ---------------- read mux ----------------
    assign D_OE = ~CS_N & ~R;

    always_comb begin
        D_OUT = 8'h00;
        if (D_OE) begin
            if (A0 == REG_STATUS) begin
                D_OUT = status;
            end else if (ne) begin
                D_OUT = mem[rd_ptr];
            end
        end
    end

    // Write-data bits with no function.
    assign unused_ok = &{1'b0, D_IN[7:5], D_IN[1]};

endmodule
